// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 5..9 data bits, optional parity, 1/2 stop bits.
// Own baud-tick divider, 3-sample majority vote, valid/ready output register.
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);
  localparam logic [PW-1:0] PH_LO   = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_HI   = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_END  = PW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);
  localparam logic          ODD     = (PARITY == 1);
  localparam logic          HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, DONE
  } state_t;

  state_t state, state_n;

  logic                 rx_q1, rx_s;
  logic [DW-1:0]        div_cnt;
  logic [PW-1:0]        ph;
  logic [3:0]           bit_cnt;
  logic                 s_lo, s_mid;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_acc, pe_acc;
  logic                 tick, decide, bit_end, vote;

  assign tick    = (state != IDLE) && (div_cnt == DIV_END);
  assign decide  = tick && (ph == PH_HI);
  assign bit_end = tick && (ph == PH_END);
  assign vote    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: begin
        if (decide && vote) state_n = IDLE;
        else if (bit_end)   state_n = DATA;
      end
      DATA:  if (bit_end && bit_cnt == LAST_D)
               state_n = HAS_PAR ? PAR : STOP;
      PAR:   if (bit_end) state_n = STOP;
      STOP:  if (decide && bit_cnt == LAST_S) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      ph      <= '0;
      bit_cnt <= '0;
      s_lo    <= 1'b0;
      s_mid   <= 1'b0;
      shreg   <= '0;
      fe_acc  <= 1'b0;
      pe_acc  <= 1'b0;
    end else begin
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DW'(1);

      if (state == IDLE)   ph <= '0;
      else if (tick)       ph <= (ph == PH_END) ? '0 : ph + PW'(1);

      if (state_n != state) bit_cnt <= '0;
      else if (bit_end)     bit_cnt <= bit_cnt + 4'd1;

      if (tick && ph == PH_LO)  s_lo  <= rx_s;
      if (tick && ph == PH_MID) s_mid <= rx_s;

      if (state == DATA && decide)
        shreg <= {vote, shreg[DATA_BITS-1:1]};

      if (state == IDLE) begin
        fe_acc <= 1'b0;
        pe_acc <= 1'b0;
      end else begin
        if (state == PAR && decide)
          pe_acc <= ^shreg ^ vote ^ ODD;
        if (state == STOP && decide && !vote)
          fe_acc <= 1'b1;
      end
    end
  end

  // A DONE coinciding with a handshake swaps words; overrun is left alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (state == DONE) begin
      if (!valid || ready) begin
        data_out   <= shreg;
        frame_err  <= fe_acc;
        parity_err <= HAS_PAR & pe_acc;
        valid      <= 1'b1;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three configurations, directed and random frames
// compared against a frame-level model of data, parity and stop bits.
module tb_uart_rx_os;

  typedef struct packed {
    logic [3:0] inst;
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk;
  logic       rst_n [3];
  logic       rx    [3];
  logic       rdy   [3];
  logic       vld   [3];
  logic       fe    [3];
  logic       pe    [3];
  logic       ov    [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int   tests = 0;
  int   fails = 0;
  rec_t exp_q [$];
  rec_t got_q [$];
  rec_t mon_r;

  uart_rx_os u0 (
    .clk(clk), .rst(rst_n[0]), .rx(rx[0]), .data_out(d0),
    .valid(vld[0]), .ready(rdy[0]), .frame_err(fe[0]),
    .parity_err(pe[0]), .overrun(ov[0])
  );

  uart_rx_os #(
    .CLK_FREQ(1_000_000), .BAUD(15625), .PARITY(2)
  ) u1 (
    .clk(clk), .rst(rst_n[1]), .rx(rx[1]), .data_out(d1),
    .valid(vld[1]), .ready(rdy[1]), .frame_err(fe[1]),
    .parity_err(pe[1]), .overrun(ov[1])
  );

  uart_rx_os #(
    .CLK_FREQ(1_000_000), .BAUD(15625),
    .DATA_BITS(7), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .rst(rst_n[2]), .rx(rx[2]), .data_out(d2),
    .valid(vld[2]), .ready(rdy[2]), .frame_err(fe[2]),
    .parity_err(pe[2]), .overrun(ov[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dout(input int i);
    case (i)
      0:       return 32'(d0);
      1:       return 32'(d1);
      default: return 32'(d2);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && rdy[i]) begin
        mon_r.inst = 4'(i);
        mon_r.d    = 9'(dout(i));
        mon_r.fe   = fe[i];
        mon_r.pe   = pe[i];
        got_q.push_back(mon_r);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; the model derives the expected word from the bits sent.
  task automatic send(input int i, input int bc, input logic [8:0] d,
                      input int nb, input int pm, input bit flip,
                      input logic [1:0] sv, input int ns,
                      input bit exp_word, input int gap);
    logic [8:0] m;
    int         ones;
    logic       pb;
    rec_t       r;
    m    = d & 9'((1 << nb) - 1);
    ones = $countones(m);
    pb   = (pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    pb   = pb ^ flip;
    rx[i] = 1'b0;
    repeat (bc) @(posedge clk);
    for (int k = 0; k < nb; k++) begin
      rx[i] = m[k];
      repeat (bc) @(posedge clk);
    end
    if (pm != 0) begin
      rx[i] = pb;
      repeat (bc) @(posedge clk);
    end
    for (int k = 0; k < ns; k++) begin
      rx[i] = sv[k];
      repeat (bc) @(posedge clk);
    end
    rx[i] = 1'b1;
    repeat (gap * bc) @(posedge clk);
    if (exp_word) begin
      r.inst = 4'(i);
      r.d    = m;
      r.fe   = (ns == 1) ? !sv[0] : !(sv[0] & sv[1]);
      if (pm == 0)      r.pe = 1'b0;
      else if (pm == 1) r.pe = ((ones + int'(pb)) % 2 == 0);
      else              r.pe = ((ones + int'(pb)) % 2 == 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic drain(input string tag);
    rec_t e, g;
    check({tag, " count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, " data"},       32'(g.d),  32'(e.d));
      check({tag, " frame_err"},  32'(g.fe), 32'(e.fe));
      check({tag, " parity_err"}, 32'(g.pe), 32'(e.pe));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [8:0] rd;
    logic [1:0] sv;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      rx[i]    = 1'b1;
      rdy[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst valid", 32'(vld[i]), 0);
      check("rst data", dout(i), 0);
      check("rst flags", {29'd0, fe[i], pe[i], ov[i]}, 0);
    end

    // Default configuration, 8N1 at 8680 ns per bit
    rdy[0] = 1'b1;
    send(0, 868, 9'h0A5, 8, 0, 0, 2'b11, 1, 1, 2);
    send(0, 868, 9'h03C, 8, 0, 0, 2'b11, 1, 1, 2);
    send(0, 868, 9'h012, 8, 0, 0, 2'b11, 1, 1, 2);
    drain("8n1");

    // Even parity, parity and framing errors, then random frames
    rdy[1] = 1'b1;
    send(1, 64, 9'h03C, 8, 2, 1, 2'b11, 1, 1, 2);
    send(1, 64, 9'h03C, 8, 2, 0, 2'b11, 1, 1, 2);
    send(1, 64, 9'h012, 8, 2, 0, 2'b10, 1, 1, 3);
    send(1, 64, 9'h0C3, 8, 2, 0, 2'b11, 1, 1, 2);
    for (int n = 0; n < 10; n++) begin
      rd = 9'($urandom_range(0, 255));
      sv = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      send(1, 64, rd, 8, 2, 1'($urandom_range(0, 1)), sv, 1, 1, 3);
    end
    drain("par");

    // Glitch shorter than half a bit is a false start
    rx[1] = 1'b0;
    repeat (12) @(posedge clk);
    rx[1] = 1'b1;
    repeat (128) @(posedge clk);
    @(negedge clk);
    check("glitch valid", 32'(vld[1]), 0);
    check("glitch words", got_q.size(), 0);
    send(1, 64, 9'($urandom_range(0, 255)), 8, 2, 0, 2'b11, 1, 1, 2);
    drain("post-glitch");

    // Overrun while the consumer stalls
    rdy[1] = 1'b0;
    send(1, 64, 9'h0A5, 8, 2, 0, 2'b11, 1, 1, 2);
    send(1, 64, 9'h03C, 8, 2, 0, 2'b11, 1, 0, 2);
    @(negedge clk);
    check("ovr data", dout(1), 32'h0A5);
    check("ovr valid", 32'(vld[1]), 1);
    check("ovr flag", 32'(ov[1]), 1);
    @(posedge clk);
    #1 rdy[1] = 1'b1;
    @(posedge clk);
    #1 rdy[1] = 1'b0;
    @(negedge clk);
    check("ack valid", 32'(vld[1]), 0);
    check("ack ovr", 32'(ov[1]), 0);
    check("ack data held", dout(1), 32'h0A5);
    drain("ovr");

    // 7 data bits, 2 stop bits, reset mid-frame
    send(2, 64, 9'($urandom_range(0, 127)), 7, 0, 0, 2'b11, 2, 0, 2);
    send(2, 64, 9'($urandom_range(0, 127)), 7, 0, 0, 2'b11, 2, 0, 2);
    @(negedge clk);
    check("u2 ovr", 32'(ov[2]), 1);
    fork
      send(2, 64, 9'h07F, 7, 0, 0, 2'b11, 2, 0, 1);
      begin
        repeat (64 * 4) @(posedge clk);
        #1 rst_n[2] = 1'b0;
      end
    join
    @(negedge clk);
    check("mid rst data", dout(2), 0);
    check("mid rst valid", 32'(vld[2]), 0);
    check("mid rst flags", {29'd0, fe[2], pe[2], ov[2]}, 0);
    #1 rst_n[2] = 1'b1;
    repeat (5) @(posedge clk);
    send(2, 64, 9'h055, 7, 0, 0, 2'b11, 2, 1, 2);
    @(negedge clk);
    check("post rst data", dout(2), 32'h55);
    check("post rst valid", 32'(vld[2]), 1);
    rdy[2] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      rd = 9'($urandom_range(0, 127));
      case ($urandom_range(0, 2))
        0:       sv = 2'b10;
        1:       sv = 2'b01;
        default: sv = 2'b11;
      endcase
      send(2, 64, rd, 7, 0, 0, sv, 2, 1, 3);
    end
    drain("7n2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
